// File: rtl/lfsr_random_unit_if.sv
// Request/response bundle for lfsr_random_unit: a draw request with its range,
// and the drawn value together with the flag that marks the fallback path.
interface lfsr_random_unit_if #(
  parameter int OUT_WIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [OUT_WIDTH-1:0] req_range;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_fallback;

  modport master (
    output req_valid, req_range, out_ready,
    input  req_ready, out_valid, out_data, out_fallback
  );

  modport slave (
    input  req_valid, req_range, out_ready,
    output req_ready, out_valid, out_data, out_fallback
  );
endinterface

// File: rtl/lfsr_random_unit.sv
// Galois-LFSR random source with entropy re-seeding, lockup recovery and
// unbiased draws in [0, range) by rejection sampling with a bounded retry count.
module lfsr_random_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int               OUT_WIDTH = 8,
  parameter int               MAX_TRIES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 free_run,
  input  logic                 seed_capture,
  output logic [OUT_WIDTH-1:0] raw_q,
  lfsr_random_unit_if.slave    bus
);

  localparam int                TRY_W       = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]  MAX_TRIES_C = TRY_W'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     lfsr_r;
  logic [WIDTH-1:0]     ent_cnt_r;
  logic [OUT_WIDTH-1:0] range_r;
  logic [OUT_WIDTH-1:0] mask_r;
  logic [TRY_W-1:0]     tries_r;

  logic [WIDTH-1:0]     lfsr_next_s;
  logic [WIDTH-1:0]     mix_s;
  logic [OUT_WIDTH-1:0] cand_s;
  logic                 accept_s;
  logic [TRY_W-1:0]     tries_next_s;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : {WIDTH{1'b0}});
  endfunction

  // Smallest all-ones mask covering r-1; r=0 wraps to all ones, r=1 gives 0.
  function automatic logic [OUT_WIDTH-1:0] range_mask(input logic [OUT_WIDTH-1:0] r);
    logic [OUT_WIDTH-1:0] m;
    m = r - OUT_WIDTH'(1);
    for (int i = 1; i < OUT_WIDTH; i++) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

  assign raw_q = lfsr_r[OUT_WIDTH-1:0];

  // Next LFSR value: lockup guard, then entropy capture, then stepping, else hold.
  always_comb begin
    mix_s       = lfsr_r ^ ent_cnt_r;
    lfsr_next_s = lfsr_r;
    if (lfsr_r == {WIDTH{1'b0}}) begin
      lfsr_next_s = SEED;
    end else if (seed_capture) begin
      lfsr_next_s = (mix_s == {WIDTH{1'b0}}) ? SEED : mix_s;
    end else if ((state_r == DRAW) || ((state_r == IDLE) && free_run)) begin
      lfsr_next_s = step(lfsr_r);
    end else begin
      lfsr_next_s = lfsr_r;
    end
  end

  // Candidate from the pre-step LFSR value; range 0 means the full output span.
  always_comb begin
    cand_s       = lfsr_r[OUT_WIDTH-1:0] & mask_r;
    accept_s     = (range_r == {OUT_WIDTH{1'b0}}) || (cand_s < range_r);
    tries_next_s = tries_r + TRY_W'(1);
  end

  // Draw FSM, LFSR and entropy counter state, and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      lfsr_r           <= SEED;
      ent_cnt_r        <= {WIDTH{1'b0}};
      range_r          <= {OUT_WIDTH{1'b0}};
      mask_r           <= {OUT_WIDTH{1'b0}};
      tries_r          <= {TRY_W{1'b0}};
      bus.req_ready    <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= {OUT_WIDTH{1'b0}};
      bus.out_fallback <= 1'b0;
    end else begin
      lfsr_r    <= lfsr_next_s;
      ent_cnt_r <= ent_cnt_r + WIDTH'(1);
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            range_r       <= bus.req_range;
            mask_r        <= range_mask(bus.req_range);
            tries_r       <= {TRY_W{1'b0}};
            bus.req_ready <= 1'b0;
            state_r       <= DRAW;
          end
        end
        DRAW: begin
          if (accept_s) begin
            bus.out_data     <= cand_s;
            bus.out_fallback <= 1'b0;
            bus.out_valid    <= 1'b1;
            state_r          <= DONE;
          end else if (tries_next_s == MAX_TRIES_C) begin
            // mask < 2*range, so a rejected candidate minus range is in range.
            bus.out_data     <= cand_s - range_r;
            bus.out_fallback <= 1'b1;
            bus.out_valid    <= 1'b1;
            state_r          <= DONE;
          end else begin
            tries_r <= tries_next_s;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state_r       <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule
